// File: rtl/usbh_pkg.sv
// Shared USB host definitions: PID constants, CRC16 constants, TX state encoding
// and a DATA-class PID validity helper.
package usbh_pkg;

  localparam logic [7:0]  PID_DATA0    = 8'hC3;
  localparam logic [7:0]  PID_DATA1    = 8'h4B;
  localparam logic [7:0]  PID_DATA2    = 8'h87;
  localparam logic [7:0]  PID_MDATA    = 8'h0F;

  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_PID    = 3'd1,
    TX_DATA   = 3'd2,
    TX_CRC_LO = 3'd3,
    TX_CRC_HI = 3'd4
  } tx_state_e;

  // Upper nibble must be the complement of the lower nibble; DATA class ends in 2'b11.
  function automatic logic pid_is_data(input logic [7:0] pid);
    return (pid[7:4] == ~pid[3:0]) && (pid[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/usbh_crc16_byte.sv
// One-byte step of the USB CRC16 (reflected poly 0xA001, LSB first); purely combinational.
module usbh_crc16_byte
  import usbh_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  // Fold the byte in, then shift out eight bits.
  always_comb begin
    crc_o = crc_i ^ {8'h00, data_i};
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0]) begin
        crc_o = (crc_o >> 4'd1) ^ CRC16_POLY_R;
      end else begin
        crc_o = crc_o >> 4'd1;
      end
    end
  end

endmodule

// File: rtl/usbh_tx_data_pkt.sv
// USB host DATA packet transmitter: PID, FIFO payload, inverted CRC16 (low byte first).
// Optional build macro USBH_TX_PID_CHECK_EN rejects non-DATA PIDs at start.
module usbh_tx_data_pkt
  import usbh_pkg::*;
#(
  parameter int LEN_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       pid_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_txvalid_o,
  input  logic             utmi_txready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  output logic             pid_err_o
);

  localparam logic [LEN_W-1:0] REM_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] REM_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  tx_state_e        state_q, state_d;
  logic [15:0]      crc_q, crc_d, crc_next_s;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       data_q, data_d;
  logic             txvalid_q, txvalid_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             pid_err_q, pid_err_d;
  logic             accept_s, need_byte_s, start_ok_s;

  usbh_crc16_byte u_crc (
    .crc_i  (crc_q),
    .data_i (data_q),
    .crc_o  (crc_next_s)
  );

`ifdef USBH_TX_PID_CHECK_EN
  assign start_ok_s = pid_is_data(pid_i);
`else
  assign start_ok_s = 1'b1;
`endif

  assign accept_s    = txvalid_q & utmi_txready_i;
  // A payload byte is needed after the PID (if any payload) and after every DATA byte but the last.
  assign need_byte_s = ((state_q == TX_PID)  && (rem_q != REM_ZERO)) ||
                       ((state_q == TX_DATA) && (rem_q >  REM_ONE));
  assign fifo_pop_o  = accept_s & need_byte_s & ~fifo_empty_i;

  assign utmi_data_o    = data_q;
  assign utmi_txvalid_o = txvalid_q;
  assign busy_o         = (state_q != TX_IDLE);
  assign done_o         = done_q;
  assign underrun_o     = underrun_q;
  assign pid_err_o      = pid_err_q;

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    rem_d      = rem_q;
    data_d     = data_q;
    txvalid_d  = txvalid_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    pid_err_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start_i && start_ok_s) begin
          crc_d     = CRC16_INIT;
          rem_d     = len_i;
          data_d    = pid_i;
          txvalid_d = 1'b1;
          state_d   = TX_PID;
        end else begin
          pid_err_d = start_i;
        end
      end
      TX_PID, TX_DATA: begin
        if (accept_s) begin
          if (state_q == TX_DATA) begin
            crc_d = crc_next_s;
            rem_d = (rem_q != REM_ZERO) ? (rem_q - REM_ONE) : rem_q;
          end else begin
            crc_d = crc_q;
          end
          if (!need_byte_s) begin
            data_d  = (state_q == TX_DATA) ? ~crc_next_s[7:0] : ~crc_q[7:0];
            state_d = TX_CRC_LO;
          end else if (!fifo_empty_i) begin
            data_d  = fifo_data_i;
            state_d = TX_DATA;
          end else begin
            txvalid_d  = 1'b0;
            underrun_d = 1'b1;
            state_d    = TX_IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      TX_CRC_LO: begin
        if (accept_s) begin
          data_d  = ~crc_q[15:8];
          state_d = TX_CRC_HI;
        end else begin
          state_d = state_q;
        end
      end
      TX_CRC_HI: begin
        if (accept_s) begin
          txvalid_d = 1'b0;
          done_d    = 1'b1;
          state_d   = TX_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        txvalid_d = 1'b0;
        state_d   = TX_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any packet in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= TX_IDLE;
      crc_q      <= CRC16_INIT;
      rem_q      <= REM_ZERO;
      data_q     <= 8'h00;
      txvalid_q  <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      pid_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      txvalid_q  <= txvalid_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      pid_err_q  <= pid_err_d;
    end
  end

endmodule

// File: doc/usbh_tx_data_pkt.md
Name: usbh_tx_data_pkt

Overview:
USB host DATA-packet transmit engine, directly downstream of the host TX byte FIFO (8-bit, first-word-fall-through, push/pop/full/empty).
- On a start command, drives the PHY UTMI-style transmit interface in this order: PID byte, then `len` payload bytes popped from the FIFO, then the CRC16 low byte, then the CRC16 high byte.
- Reports completion or FIFO underrun to the host controller FSM.

Parameters:
- LEN_W, 11, width of payload length (max 1023 bytes, isochronous maximum)

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  start packet; sampled only in IDLE
- pid_i  input  8  full PID byte (e.g. DATA0=0xC3, DATA1=0x4B); sampled on accepted start
- len_i  input  LEN_W  payload byte count; sampled on accepted start; 0 is legal
- fifo_data_i  input  8  TX FIFO head byte (valid while ~fifo_empty_i)
- fifo_empty_i  input  1  TX FIFO empty
- fifo_pop_o  output  1  pop TX FIFO (combinational)
- utmi_data_o  output  8  transmit byte (registered)
- utmi_txvalid_o  output  1  transmit valid (registered)
- utmi_txready_i  input  1  PHY accepted current byte
- busy_o  output  1  not in IDLE
- done_o  output  1  one-cycle pulse, packet fully accepted
- underrun_o  output  1  one-cycle pulse, packet aborted due to FIFO underrun
- pid_err_o  output  1  one-cycle pulse, bad PID rejected (0 when USBH_TX_PID_CHECK_EN is undefined)

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 0xFFFF, remaining counter 0. Reset mid-packet drops utmi_txvalid_o asynchronously; the partial packet is abandoned.
- Accept rule: a byte is accepted on any cycle with utmi_txvalid_o & utmi_txready_i. While unaccepted, utmi_data_o and utmi_txvalid_o are held stable.
- States: IDLE, PID, DATA, CRC_LO, CRC_HI.
- IDLE
  - start_i=1: latch pid_i and len_i, set CRC=0xFFFF, load utmi_data_o=pid_i, txvalid=1, go to PID.
  - Latency: start in cycle N puts the PID on the bus in cycle N+1.
  - start_i while busy is ignored.
- PID accepted:
  - remaining==0: load ~CRC low byte, go to CRC_LO.
  - Otherwise, if ~fifo_empty_i: pop, load fifo_data_i, go to DATA.
  - Otherwise: underrun.
- DATA accepted:
  - Fold the accepted byte into the CRC and decrement remaining.
  - If remaining after the decrement is 0: load the final CRC's inverted low byte, go to CRC_LO.
  - Otherwise, same pop/load/underrun rule as PID.
- CRC_LO accepted: load inverted CRC high byte, go to CRC_HI.
- CRC_HI accepted: txvalid=0, done_o pulse, go to IDLE.
- fifo_pop_o is asserted only in the same cycle as an accept that loads a FIFO byte. Never pop when fifo_empty_i=1.
- Underrun (FIFO empty when the next payload byte is needed):
  - txvalid=0 next cycle, underrun_o pulse, go to IDLE.
  - No CRC is sent.
  - The FIFO is not flushed by this block.
- CRC16 (USB):
  - Reflected polynomial 0xA001, LSB-first, init 0xFFFF over payload bytes only (PID excluded).
  - Transmitted value is the bitwise inverse, low byte first.
- Counter: remaining is LEN_W bits; it never decrements below 0.
- busy_o = (state != IDLE). done_o and underrun_o are never high simultaneously.

Optional Feature:
USBH_TX_PID_CHECK_EN
- Defined: start is accepted only if pid_i[7:4] == ~pid_i[3:0] and pid_i[1:0] == 2'b11 (DATA-class PID). Otherwise pid_err_o pulses one cycle after start, nothing is transmitted, and the block stays in IDLE.
- Undefined: pid_i is transmitted unchecked and pid_err_o is tied 0.

Decomposition:
- usbh_pkg holds:
  - PID constants: PID_DATA0=8'hC3, PID_DATA1=8'h4B, PID_DATA2=8'h87, PID_MDATA=8'h0F
  - CRC16_INIT=16'hFFFF, CRC16_POLY_R=16'hA001
  - tx state enum typedef
- Sub-module usbh_crc16_byte: combinational, crc_i[15:0] + data_i[7:0] -> crc_o[15:0]. Reused by the RX CRC checker.

Test Plan:
1. DATA0 with len=0, txready always 1 -> bus carries C3, 00, 00; done_o pulses one cycle after the last accept; fifo_pop_o never asserted.
2. DATA1 with len=1, FIFO pre-loaded {00} -> bus carries 4B, 00, 40, BF; exactly one pop.
3. len=64 random payload, txready toggled randomly -> bytes held stable while unaccepted; 64 pops; CRC bytes match the software model; no drops or duplicates.
4. len=4 with FIFO holding only 2 bytes -> C3, b0, b1 sent; txvalid drops; underrun_o pulses; no CRC sent; busy_o=0 after.
5. Assert rst_i mid-DATA, then start a new len=1 packet -> txvalid drops immediately; new packet is correct with CRC re-initialised; start_i pulsed during busy is ignored.
6. With USBH_TX_PID_CHECK_EN: pid_i=8'hC4 -> pid_err_o pulses, txvalid stays 0. Without the macro: pid_i=8'hC4 is sent.
